byte_serial_add_ctrl: RTL
=========================

BYTE_SERIAL_ADD_CTRL -- requirements
Module: byte_serial_add_ctrl

Interface
REQ-001 Parameter: NBYTES, default 4, number of 8-bit limbs per operand; SHALL be legal for 2..16.
REQ-002 Clocking SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start_valid  input  1  requester presents an operation.
REQ-006 start_ready  output  1  block can accept an operation.
REQ-007 op_a  input  8*NBYTES  operand A, unsigned or two's complement.
REQ-008 op_b  input  8*NBYTES  operand B.
REQ-009 op_sub  input  1  1 = A-B, 0 = A+B.
REQ-010 cin  input  1  carry-in for add; ignored when op_sub=1.
REQ-011 res_valid  output  1  result, cout and ovf are valid.
REQ-012 res_ready  input  1  consumer accepts the result.
REQ-013 result  output  8*NBYTES  sum or difference.
REQ-014 cout  output  1  final carry out; for subtract, 1 = no borrow.
REQ-015 ovf  output  1  signed overflow of the full-width operation.
REQ-016 busy  output  1  high in RUN and DONE.

Function
REQ-017 FSM states SHALL be IDLE, RUN and DONE.
REQ-018 start_ready SHALL be 1 only in IDLE.
REQ-019 Accept occurs on a clock edge with start_valid=1 and start_ready=1: latch op_a, op_b (inverted if op_sub), op_sub; init carry = op_sub ? 1 : cin; byte index = 0; go to RUN.
REQ-020 RUN: each cycle, feed byte[index] of latched A and B' plus carry register to the single 8-bit adder; write sum into result byte[index]; update carry register from adder cout; index+1.
REQ-021 Leaving RUN: after byte NBYTES-1 is processed, go to DONE; result, cout and ovf then become final.
REQ-022 Latency: accept at edge k; res_valid SHALL be 1 after edge k+NBYTES.
REQ-023 ovf SHALL be 1 iff MSB(A) equals MSB(B') and MSB(result) differs from MSB(A).
REQ-024 DONE: res_valid=1; result, cout and ovf held stable until an edge with res_ready=1, which returns to IDLE with res_valid=0.
REQ-025 In IDLE and RUN, res_ready SHALL have no effect.
REQ-026 While start_ready=0, start_valid SHALL be ignored; no operation is queued.
REQ-027 Result and start handshakes SHALL NOT complete in the same cycle; a new accept is possible at the earliest one cycle after DONE exits.
REQ-028 Arithmetic SHALL be modulo 2^(8*NBYTES); carry beyond the MSB appears only on cout.
REQ-029 In IDLE, result, cout and ovf SHALL retain the last completed values.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE and set result=0, cout=0, ovf=0, res_valid=0, busy=0, start_ready=1.
REQ-031 Reset asserted during RUN or DONE SHALL discard the partial or final result.
REQ-032 After rst_n deasserts, the first accept SHALL behave exactly as after power-up.

Structure
REQ-033 Package byte_serial_add_pkg SHALL hold the state enum (IDLE, RUN, DONE), BYTE_W=8 and the default NBYTES.
REQ-034 The block SHALL instantiate exactly one ripple_adder_8 (ports sum, cout, a, b, cin) as the shared datapath.
REQ-035 The byte index counter SHALL be $clog2(NBYTES) bits wide.

Verification (NBYTES=4)
REQ-036 0x000000FF + 0x00000001, cin=0 -> result 0x00000100, cout=0, ovf=0, res_valid exactly 4 cycles after accept.
REQ-037 0xFFFFFFFF + 0x00000001 -> result 0x00000000, cout=1, ovf=0.
REQ-038 Subtract 0x00000005 - 0x00000007 -> result 0xFFFFFFFE, cout=0, ovf=0; subtract 7-5 -> 0x00000002, cout=1.
REQ-039 0x7FFFFFFF + 0x00000001 -> result 0x80000000, ovf=1, cout=0.
REQ-040 Hold res_ready=0 for 5 cycles in DONE with start_valid=1 -> outputs stable, start_ready=0, no second accept; the first edge with res_ready=1 returns to IDLE.
REQ-041 rst_n pulse during RUN at byte index 2 -> outputs zero at once, IDLE; the next operation 0x12345678 + 0x11111111 -> 0x23456789.

Source files
------------

// File: rtl/byte_serial_add_pkg.sv
// Shared types and constants for the byte-serial adder.
// Holds the controller state encoding and limb width.
package byte_serial_add_pkg;

    localparam int BYTE_W     = 8;
    localparam int NBYTES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/byte_serial_add_ctrl_ripple_adder_8.sv
// 8-bit ripple-carry adder.
// Shared datapath used once per limb by the controller.
module ripple_adder_8
    import byte_serial_add_pkg::*;
(
    output logic [BYTE_W-1:0] sum,
    output logic              cout,
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin
);

    // Full-adder chain, LSB first.
    always_comb begin
        logic c;
        c = cin;
        sum = '0;
        for (int i = 0; i < BYTE_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/byte_serial_add_ctrl.sv
// Byte-serial add/subtract controller.
// One limb per cycle through a single shared 8-bit adder.
module byte_serial_add_ctrl
    import byte_serial_add_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_valid,
    output logic                     start_ready,
    input  logic [8*NBYTES-1:0]      op_a,
    input  logic [8*NBYTES-1:0]      op_b,
    input  logic                     op_sub,
    input  logic                     cin,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [8*NBYTES-1:0]      result,
    output logic                     cout,
    output logic                     ovf,
    output logic                     busy
);

    localparam int W    = BYTE_W * NBYTES;
    localparam int IDXW = $clog2(NBYTES);
    localparam int MSB  = W - 1;

    localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

    state_t state_q, state_d;

    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic [IDXW-1:0] idx_q, idx_d;

    logic [BYTE_W-1:0] a_byte;
    logic [BYTE_W-1:0] b_byte;
    logic [BYTE_W-1:0] sum_byte;
    logic              add_co;
    logic              last_byte;

    assign a_byte    = a_q[idx_q*BYTE_W +: BYTE_W];
    assign b_byte    = b_q[idx_q*BYTE_W +: BYTE_W];
    assign last_byte = (idx_q == LAST);

    ripple_adder_8 u_add (
        .sum  (sum_byte),
        .cout (add_co),
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry_q)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: accept in IDLE, walk limbs in RUN, wait for consumer in DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_valid) state_d = RUN;
            RUN:  if (last_byte)   state_d = DONE;
            DONE: if (res_ready)   state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state.
    always_comb begin
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        unique case (state_q)
            IDLE: start_ready = 1'b1;
            RUN:  busy        = 1'b1;
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
            end
            default: start_ready = 1'b0;
        endcase
    end

    // Datapath next state: latch operands, then accumulate one limb per cycle.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (start_valid) begin
                    a_d     = op_a;
                    b_d     = op_sub ? ~op_b : op_b;
                    carry_d = op_sub | cin;
                    idx_d   = '0;
                end
            end
            RUN: begin
                res_d[idx_q*BYTE_W +: BYTE_W] = sum_byte;
                carry_d = add_co;
                idx_d   = idx_q + 1'b1;
                if (last_byte) begin
                    idx_d  = '0;
                    cout_d = add_co;
                    ovf_d  = (a_q[MSB] == b_q[MSB]) &&
                             (sum_byte[BYTE_W-1] != a_q[MSB]);
                end
            end
            default: begin
                idx_d = idx_q;
            end
        endcase
    end

    // Datapath registers; reset discards any partial or final result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign result = res_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule
